// File: rtl/crc_pkg.sv
// Shared definitions for the CRC encoder: sizes, default generator, FSM states.
// The SEND state is only reachable when CRC_SERIAL_OUT_EN is defined.
package crc_pkg;

  localparam int unsigned CRC_M = 5;
  localparam int unsigned CRC_K = 10;

  localparam logic [4:0] CRC_G_DEFAULT = 5'b10011;

  // Codeword length: message bits followed by the (m-1)-bit remainder.
  function automatic int unsigned crc_n(input int unsigned k, input int unsigned m);
    return k + m - 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_SEND  = 2'd3
  } crc_state_e;

endpackage

// File: rtl/crc_encoder_if.sv
// Start/done handshake bundle between a requester (master) and the encoder (slave).
// Serial transmit signals exist only when CRC_SERIAL_OUT_EN is defined.
interface crc_encoder_if
  import crc_pkg::*;
#(
  parameter int unsigned m = CRC_M,
  parameter int unsigned k = CRC_K
);

  localparam int unsigned n = crc_n(k, m);

  logic         start;
  logic [k-1:0] msg_in;
  logic [m-1:0] G;
  logic         busy;
  logic         done;
  logic [m-2:0] remainder;
  logic [n-1:0] codeword;
`ifdef CRC_SERIAL_OUT_EN
  logic         tx_valid;
  logic         tx_bit;
`endif

  modport master (
    output start, msg_in, G,
`ifdef CRC_SERIAL_OUT_EN
    input  tx_valid, tx_bit,
`endif
    input  busy, done, remainder, codeword
  );

  modport slave (
    input  start, msg_in, G,
`ifdef CRC_SERIAL_OUT_EN
    output tx_valid, tx_bit,
`endif
    output busy, done, remainder, codeword
  );

endinterface

// File: rtl/crc_lfsr_step.sv
// One bit of modulo-2 long division: shifts the message bit through the remainder.
// The generator's leading term is implicit, so only its low m-1 bits are needed.
module crc_lfsr_step #(
  parameter int unsigned m = 5
) (
  input  logic [m-2:0] rem,
  input  logic         bit_in,
  input  logic [m-2:0] g,
  output logic [m-2:0] next_rem_c
);

  logic fb_c;

  always_comb begin
    fb_c       = bit_in ^ rem[m-2];
    next_rem_c = {rem[m-3:0], 1'b0} ^ (fb_c ? g : '0);
  end

endmodule

// File: rtl/crc_encoder.sv
// Bit-serial CRC encoder: k-cycle division producing remainder and {msg, remainder}.
// Define CRC_SERIAL_OUT_EN to also shift the codeword out MSB first before done.
module crc_encoder
  import crc_pkg::*;
#(
  parameter int unsigned m = CRC_M,
  parameter int unsigned k = CRC_K
) (
  input logic           clk,
  input logic           reset,
  crc_encoder_if.slave  bus
);

  localparam int unsigned n  = crc_n(k, m);
  localparam int unsigned CW = $clog2(n + 1);

  crc_state_e   state;
  logic [k-1:0] msg_r;
  logic [k-1:0] msg_sh;
  logic [m-2:0] g_r;
  logic [m-2:0] rem_r;
  logic [m-2:0] rem_next_c;
  logic [CW-1:0] cnt;
  logic         busy_r;
  logic         done_r;
  logic [m-2:0] remainder_r;
  logic [n-1:0] codeword_r;
`ifdef CRC_SERIAL_OUT_EN
  logic [n-1:0] tx_sh;
  logic         tx_valid_r;
  logic         tx_bit_r;
`endif

  crc_lfsr_step #(.m(m)) u_step (
    .rem       (rem_r),
    .bit_in    (msg_sh[k-1]),
    .g         (g_r),
    .next_rem_c(rem_next_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      msg_r       <= '0;
      msg_sh      <= '0;
      g_r         <= '0;
      rem_r       <= '0;
      cnt         <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      remainder_r <= '0;
      codeword_r  <= '0;
`ifdef CRC_SERIAL_OUT_EN
      tx_sh       <= '0;
      tx_valid_r  <= 1'b0;
      tx_bit_r    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            msg_r  <= bus.msg_in;
            msg_sh <= bus.msg_in;
            g_r    <= bus.G[m-2:0];
            rem_r  <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          rem_r  <= rem_next_c;
          msg_sh <= msg_sh << 1;
          if (cnt == CW'(k - 1)) begin
            cnt <= '0;
`ifdef CRC_SERIAL_OUT_EN
            // First codeword bit is presented on the same edge SEND is entered.
            state      <= ST_SEND;
            tx_sh      <= {msg_r, rem_next_c};
            tx_valid_r <= 1'b1;
            tx_bit_r   <= msg_r[k-1];
`else
            state       <= ST_DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            remainder_r <= rem_next_c;
            codeword_r  <= {msg_r, rem_next_c};
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef CRC_SERIAL_OUT_EN
        ST_SEND: begin
          tx_sh <= tx_sh << 1;
          if (cnt == CW'(n - 1)) begin
            cnt         <= '0;
            tx_valid_r  <= 1'b0;
            tx_bit_r    <= 1'b0;
            state       <= ST_DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            remainder_r <= rem_r;
            codeword_r  <= {msg_r, rem_r};
          end else begin
            cnt      <= cnt + CW'(1);
            tx_bit_r <= tx_sh[n-2];
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.remainder = remainder_r;
  assign bus.codeword  = codeword_r;
`ifdef CRC_SERIAL_OUT_EN
  assign bus.tx_valid  = tx_valid_r;
  assign bus.tx_bit    = tx_bit_r;
`endif

endmodule

// File: tb/tb_crc_encoder.sv
// Directed + randomized bench for crc_encoder against a polynomial long-division model.
// Build with CRC_SERIAL_OUT_EN to also cover the serial codeword output.
module tb_crc_encoder;
  import crc_pkg::*;

  localparam int unsigned M = CRC_M;
  localparam int unsigned K = CRC_K;
  localparam int unsigned N = K + M - 1;
`ifdef CRC_SERIAL_OUT_EN
  localparam int unsigned LAT = K + N;
`else
  localparam int unsigned LAT = K;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  crc_encoder_if #(.m(M), .k(K)) bus ();

  crc_encoder #(.m(M), .k(K)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [N-1:0] tx_seq;
  int           tx_cnt;

  // Remainder of v(x) divided by g(x), with g's leading term forced to 1.
  function automatic logic [M-2:0] poly_mod(input logic [N-1:0] v, input logic [M-1:0] g);
    logic [N-1:0] d;
    logic [N-1:0] div;
    d   = v;
    div = N'({1'b1, g[M-2:0]});
    for (int i = N - 1; i >= int'(M - 1); i--)
      if (d[i]) d = d ^ (div << (i - int'(M - 1)));
    return d[M-2:0];
  endfunction

  function automatic logic [M-2:0] ref_rem(input logic [K-1:0] msg, input logic [M-1:0] g);
    return poly_mod({msg, {(M-1){1'b0}}}, g);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [K-1:0] msg, input logic [M-1:0] g);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.msg_in = msg;
    bus.G      = g;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.msg_in = K'($urandom);
    bus.G      = M'($urandom);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("done_after_start", 32'(bus.done), 32'd0);
  endtask

  // Counts edges after the accepting edge until done; optionally pulses start once.
  task automatic wait_done(input int inject_at, output int cyc);
    cyc    = 0;
    tx_cnt = 0;
    tx_seq = '0;
    while (!bus.done && cyc < 200) begin
      if (cyc == inject_at) begin
        bus.start  = 1'b1;
        bus.msg_in = K'($urandom);
        bus.G      = M'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
`ifdef CRC_SERIAL_OUT_EN
      if (bus.tx_valid) begin
        tx_seq = {tx_seq[N-2:0], bus.tx_bit};
        tx_cnt++;
      end
`endif
    end
    bus.start = 1'b0;
  endtask

  task automatic run_check(input logic [K-1:0] msg, input logic [M-1:0] g, input int inject_at);
    int           cyc;
    logic [M-2:0] exp_rem;
    exp_rem = ref_rem(msg, g);
    launch(msg, g);
    wait_done(inject_at, cyc);
    chk("latency", 32'(cyc), 32'(LAT));
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("remainder", 32'(bus.remainder), 32'(exp_rem));
    chk("codeword", 32'(bus.codeword), 32'({msg, exp_rem}));
    chk("loopback_syndrome", 32'(poly_mod(bus.codeword, g)), 32'd0);
`ifdef CRC_SERIAL_OUT_EN
    chk("tx_count", 32'(tx_cnt), 32'(N));
    chk("tx_bits", 32'(tx_seq), 32'({msg, exp_rem}));
`endif
  endtask

  initial begin
    logic [K-1:0] msg;
    logic [M-1:0] g;
    logic [N-1:0] cw_flip;
    logic [M-2:0] held_rem;
    int           pos;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.msg_in = '0;
    bus.G      = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_codeword", 32'(bus.codeword), 32'd0);
`ifdef CRC_SERIAL_OUT_EN
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_bit", 32'(bus.tx_bit), 32'd0);
`endif
    reset = 1'b0;

    // Textbook vector.
    run_check(10'b1101011011, CRC_G_DEFAULT, -1);
    chk("tv1_remainder", 32'(bus.remainder), 32'b1110);
    chk("tv1_codeword", 32'(bus.codeword), 32'b11010110111110);

    // Outputs hold while idle in DONE.
    held_rem = bus.remainder;
    repeat (3) @(negedge clk);
    chk("done_held", 32'(bus.done), 32'd1);
    chk("rem_held", 32'(bus.remainder), 32'(held_rem));

    run_check(10'b0000000001, CRC_G_DEFAULT, -1);
    chk("tv2_remainder", 32'(bus.remainder), 32'b0011);
    chk("tv2_codeword", 32'(bus.codeword), 32'b00000000010011);
    run_check(10'b1000000000, CRC_G_DEFAULT, -1);
    chk("tv3_remainder", 32'(bus.remainder), 32'b1101);
    chk("tv3_codeword", 32'(bus.codeword), 32'b10000000001101);

    // Zero message with a start pulse arriving mid-computation.
    run_check(10'b0000000000, CRC_G_DEFAULT, 3);
    chk("tv4_remainder", 32'(bus.remainder), 32'd0);

    // Reset partway through the division.
    launch(10'b1101011011, CRC_G_DEFAULT);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_remainder", 32'(bus.remainder), 32'd0);
    chk("mid_rst_codeword", 32'(bus.codeword), 32'd0);
    reset = 1'b0;
    run_check(10'b1101011011, CRC_G_DEFAULT, -1);

    // Generator with only the implicit leading term, and with G[m-1] cleared.
    run_check(K'($urandom), 5'b10000, -1);
    chk("g_zero_remainder", 32'(bus.remainder), 32'd0);
    run_check(10'b1101011011, 5'b00011, -1);
    chk("g_msb_ignored", 32'(bus.remainder), 32'b1110);

    // Random messages and generators, plus single-bit error detection for G=10011.
    for (int it = 0; it < 20; it++) begin
      msg = K'($urandom);
      g   = (it % 2 == 0) ? CRC_G_DEFAULT : M'($urandom);
      run_check(msg, g, (it % 3 == 0) ? int'($urandom_range(0, K - 1)) : -1);
      if (g == CRC_G_DEFAULT) begin
        pos     = int'($urandom_range(0, N - 1));
        cw_flip = bus.codeword ^ (N'(1) << pos);
        chk("flip_detect", 32'(poly_mod(cw_flip, g) != '0), 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_encoder.md
Name: crc_encoder

Overview:
- Transmit-side partner of the `crc` checker. Takes a K-bit message and generator G, performs bit-serial modulo-2 long division, and produces the (M-1)-bit remainder and the N-bit codeword {msg, remainder}, N = K+M-1.
- Same start/done handshake style as `crc`, so a codeword produced here can be fed straight into `crc`'s `data_in`, where it must yield `error`=0.

Parameters:
- m, 5, generator length in bits; G[m-1] is the implied leading term.
- k, 10, message length in bits.
- n, k+m-1 = 14, codeword length; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- msg_in  input  k  message, MSB first; captured on the accepting edge
- G  input  m  generator polynomial; captured on the accepting edge
- busy  output  1  high while a computation is in progress
- done  output  1  level; high from completion until the next accepted start or reset
- remainder  output  m-1  CRC remainder; valid while done=1
- codeword  output  n  {msg, remainder}; valid while done=1

Behaviour:
- Reset (synchronous, takes priority over everything): state=IDLE; busy, done, remainder, codeword, bit counter and internal registers all 0.
- FSM states: IDLE, SHIFT, DONE (plus SEND with the optional feature).
  - IDLE: start=1 -> capture msg_in and G, clear the remainder register, set count=0, busy=1, go to SHIFT.
  - SHIFT: one message bit per cycle, MSB first.
    - fb = msg_bit ^ rem[m-2]
    - rem <= {rem[m-3:0], 0} ^ (fb ? G[m-2:0] : 0)
    - After the k-th shift edge: go to DONE, busy=0, done=1, remainder=rem, codeword={msg, rem}.
  - DONE: outputs held stable. start=1 -> treated exactly as start in IDLE (done drops to 0 on that same edge).
- Latency: start accepted at edge E0 -> busy=1 after E0 -> done=1 after edge E0+k (k=10 cycles).
- start while busy: ignored, with no effect on the running computation.
- G[m-1] is never read; the leading 1 is implicit. G=0 -> remainder 0.
- Inputs changing after capture: no effect on the result.
- Reset mid-SHIFT: abort, all outputs return to 0 on the next edge.

Optional Feature:
- Macro: CRC_SERIAL_OUT_EN.
- Defined:
  - Extra output ports `tx_valid` (1) and `tx_bit` (1).
  - After SHIFT the FSM enters SEND for n cycles. tx_valid=1 and tx_bit carries the codeword MSB first, one bit per cycle.
  - busy stays 1 during SEND. done rises after the last bit, so latency = k+n cycles.
  - Reset clears tx_valid and tx_bit to 0.
- Undefined: the ports and the SEND state do not exist; SHIFT goes directly to DONE.

Decomposition:
- Package `crc_pkg`:
  - FSM state encoding typedef
  - default generator constant CRC_G_DEFAULT = 5'b10011
  - localparam helper for n = k+m-1
- One natural sub-module: `crc_lfsr_step`, a combinational single-bit division step (rem, bit, G -> next rem). It can be shared with the checker later.

Test Plan:
- G=10011, msg=1101011011, start pulse -> done=1 after exactly 10 cycles; remainder=1110, codeword=11010110111110.
- G=10011, msg=0000000001 -> remainder=0011, codeword=00000000010011. Then msg=1000000000 restarted from DONE -> remainder=1101, codeword=10000000001101.
- msg=0000000000 -> remainder=0000. Second start pulse at cycle 3 of SHIFT -> ignored; done still arrives at cycle 10 with the correct result.
- Reset asserted at cycle 5 of SHIFT -> next edge: busy=0, done=0, remainder=0, codeword=0, state IDLE. A new start then completes normally.
- Loopback: feed the codeword 11010110111110 into `crc` (m=5, n=14) -> error=0. Flip one bit -> error=1.
- With CRC_SERIAL_OUT_EN, msg=1101011011 -> tx_valid high for 14 cycles, tx_bit sequence 1,1,0,1,0,1,1,0,1,1,1,1,1,0; done rises after 24 cycles.
